// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - scoreboard interlock and flush controller beside the ID stage
module hazard_ctrl #(
    parameter int NREG     = 32,
    parameter int RAW_DIST = 3,
    parameter int CNT_W    = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     id_valid,
    input  logic [$clog2(NREG)-1:0]  id_rs,
    input  logic [$clog2(NREG)-1:0]  id_rt,
    input  logic                     id_use_rs,
    input  logic                     id_use_rt,
    input  logic                     id_wr_en,
    input  logic [$clog2(NREG)-1:0]  id_wr_reg,
    input  logic                     id_jump,
    input  logic                     ex_br_taken,
    output logic                     pc_hold,
    output logic                     fd_hold,
    output logic                     fd_flush,
    output logic                     de_bubble,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [CNT_W-1:0]         flush_cnt
);

    localparam int RW = $clog2(NREG);
    localparam int PW = $clog2(RAW_DIST + 1);

    logic [NREG-1:0][PW-1:0] pend;
    logic rs_busy;
    logic rt_busy;
    logic stall;
    logic issue;
    logic load;
    logic flush_ev;

    always_comb begin
        rs_busy  = id_use_rs && (pend[id_rs] != '0);
        rt_busy  = id_use_rt && (pend[id_rt] != '0);
        // A taken branch kills the ID instruction, so it can never stall
        stall    = id_valid && !ex_br_taken && (rs_busy || rt_busy);
        issue    = id_valid && !stall && !ex_br_taken;
        load     = issue && id_wr_en && (id_wr_reg != '0);
        flush_ev = ex_br_taken || (id_jump && issue);
    end

    assign pc_hold   = stall;
    assign fd_hold   = stall;
    assign fd_flush  = flush_ev;
    assign de_bubble = stall || ex_br_taken;

    // Register 0 stays clear; a fresh load overrides the decrement (in-order WAW)
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend <= '0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                if (r == 0)
                    pend[r] <= '0;
                else if (load && (id_wr_reg == RW'(r)))
                    pend[r] <= PW'(RAW_DIST);
                else if (pend[r] != '0)
                    pend[r] <= pend[r] - PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_ev && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule
